soc_system_pio_out_pulse: RTL
=============================

Name: soc_system_pio_out_pulse

Overview:
- Avalon-MM slave output PIO: the write-direction counterpart of the system's input PIO slaves.
- The HPS/Nios writes a data register that drives `out_port` directly. The chess-clock logic uses it for LEDs, buzzer and mode lines.
- Adds atomic bit set/clear and a hardware one-shot pulse generator. Software can then assert timed strobes without busy-waiting.
- Sits on the lightweight HPS-to-FPGA bridge alongside the input PIOs. Fixed 1-cycle read latency, no waitrequest.

Parameters:
- WIDTH, 32, number of `out_port` bits (1..32); register bits above WIDTH read as 0 and ignore writes.
- RESET_VALUE, 0, reset value of the DATA register (WIDTH bits).
- LEN_WIDTH, 16, width of the PULSE_LEN register and the pulse down-counter.
- DEFAULT_LEN, 1, reset value of PULSE_LEN.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  3  Avalon word address
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  registered read data
- out_port  output  WIDTH  PIO output pins

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. On reset:
  - data_reg = RESET_VALUE, pulse_len = DEFAULT_LEN, pulse_mask = 0, cnt = 0, state = IDLE.
  - readdata = 0; out_port = RESET_VALUE.
  - Reset mid-pulse aborts the pulse immediately (asynchronous).
- Write qualifier: wr = chipselect & ~write_n, sampled on the clk rising edge.
- Register map (writes use writedata[WIDTH-1:0] unless noted):
  - 0 DATA: RW; wr loads data_reg.
  - 1 PULSE_LEN: RW, LEN_WIDTH bits zero-extended on read.
  - 2 PULSE: W = trigger mask; R = current pulse_mask.
  - 3 STATUS: RO; bit0 = busy (state == ACTIVE), bits 31:1 = 0.
  - 4 OUTSET: W only; data_reg <= data_reg | writedata; reads 0.
  - 5 OUTCLEAR: W only; data_reg <= data_reg & ~writedata; reads 0.
  - 6, 7: reserved; writes ignored, reads 0.
- Read: readdata <= mux(address) on every clk edge, unconditionally (no chipselect gating).
  - Data is valid the cycle after the address is presented.
  - A read in the same cycle as a write to the same register returns the pre-write value.
- Output: out_port = data_reg ^ pulse_mask, purely combinational from registers. Pulsed bits invert relative to DATA.
- Pulse FSM, states IDLE and ACTIVE:
  - IDLE, wr to 2 with (writedata & WIDTH mask) != 0 and pulse_len != 0: pulse_mask <= masked writedata; cnt <= pulse_len; -> ACTIVE.
  - IDLE, wr to 2 with zero mask or pulse_len == 0: ignored, stays IDLE.
  - ACTIVE, no trigger: cnt <= cnt-1. At cnt == 1: pulse_mask <= 0, cnt <= 0, -> IDLE.
  - Resulting timing: out_port shows the pulse for exactly pulse_len cycles, starting the cycle after the write edge.
  - ACTIVE, retrigger (wr to 2, nonzero mask, pulse_len != 0): pulse_mask <= pulse_mask | new; cnt <= pulse_len. Retrigger takes priority over expiry in the same cycle.
- Writing PULSE_LEN while ACTIVE does not affect the running count; the new value applies to the next trigger.
- DATA/OUTSET/OUTCLEAR writes during a pulse update data_reg normally. out_port reflects the new data_reg XOR the active mask.
- Max pulse: 2^LEN_WIDTH-1 cycles. No counter wrap; cnt never decrements below 1 while ACTIVE.

Test Plan:
- Reset -> read addr 0 = 0x00000000, addr 1 = 0x00000001, addr 3 = 0; out_port = 0. Assert reset_n mid-pulse -> out_port returns to data_reg value the same cycle.
- Write addr 0 = 0xA5A5_0F0F, read addr 0 -> readdata 0xA5A5_0F0F one cycle after address. Write addr 4 = 0x0000_00F0 -> out_port 0xA5A5_0FFF. Write addr 5 = 0xA000_0000 -> out_port 0x05A5_0FFF.
- DATA = 0. Write addr 1 = 5, then addr 2 = 0x0000_0003 -> out_port = 0x3 for exactly 5 cycles, then 0. STATUS bit0 = 1 during those cycles, then 0.
- Retrigger: PULSE_LEN = 10; trigger 0x1; 4 cycles later trigger 0x4 -> out_port = 0x1, then 0x5 for 10 cycles after the second write. Total pulse on bit0 = 14 cycles.
- PULSE_LEN = 0, write addr 2 = 0xFF -> no change on out_port, busy stays 0. Write addr 2 = 0 with len 3 -> ignored.
- WIDTH = 8 build: write addr 0 = 0xFFFF_FF3C -> read 0x0000_003C, out_port = 0x3C. Reads of addr 4..7 = 0. Write addr 6 has no effect.

Source files
------------

// File: rtl/soc_system_pio_out_pulse_if.sv
// Avalon-MM slave bus bundle for the pulse-capable output PIO.
// Fixed 1-cycle read latency, so there is no waitrequest or readdatavalid.
interface soc_system_pio_out_pulse_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_system_pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear and a hardware one-shot pulse.
// Pulsed bits of out_port are inverted relative to DATA for pulse_len cycles.
module soc_system_pio_out_pulse #(
  parameter int unsigned WIDTH       = 32,
  parameter logic [31:0] RESET_VALUE = '0,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned DEFAULT_LEN = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  soc_system_pio_out_pulse_if.slave     bus,
  output logic [WIDTH-1:0]              out_port
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t               state, state_next;
  logic [WIDTH-1:0]     data_reg;
  logic [WIDTH-1:0]     pulse_mask, mask_next;
  logic [LEN_WIDTH-1:0] pulse_len;
  logic [LEN_WIDTH-1:0] cnt, cnt_next;
  logic [WIDTH-1:0]     wdata;
  logic [31:0]          rd_mux;
  logic                 wr;
  logic                 trigger;

  assign wr      = bus.chipselect & ~bus.write_n;
  assign wdata   = bus.writedata[WIDTH-1:0];
  assign trigger = wr && (bus.address == 3'd2) && (|wdata) && (pulse_len != '0);

  assign out_port = data_reg ^ pulse_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg  <= RESET_VALUE[WIDTH-1:0];
      pulse_len <= LEN_WIDTH'(DEFAULT_LEN);
    end else if (wr) begin
      case (bus.address)
        3'd0:    data_reg  <= wdata;
        3'd1:    pulse_len <= bus.writedata[LEN_WIDTH-1:0];
        3'd4:    data_reg  <= data_reg | wdata;
        3'd5:    data_reg  <= data_reg & ~wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pulse_mask <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_next;
      pulse_mask <= mask_next;
      cnt        <= cnt_next;
    end
  end

  // A retrigger reloads the count even on the cycle the pulse would expire.
  always_comb begin
    state_next = state;
    mask_next  = pulse_mask;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (trigger) begin
          mask_next  = wdata;
          cnt_next   = pulse_len;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (trigger) begin
          mask_next = pulse_mask | wdata;
          cnt_next  = pulse_len;
        end else if (cnt == LEN_ONE) begin
          mask_next  = '0;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - LEN_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      3'd0:    rd_mux[WIDTH-1:0]     = data_reg;
      3'd1:    rd_mux[LEN_WIDTH-1:0] = pulse_len;
      3'd2:    rd_mux[WIDTH-1:0]     = pulse_mask;
      3'd3:    rd_mux[0]             = (state == ACTIVE);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rd_mux;
  end

endmodule
